regfile_seq: RTL and testbench

- Sequencer for the 8-entry dual-port register file of the 8-bit core.
- Accepts one register-transfer command at a time from the instruction controller.
- Drives the register file's write enable, source select, read/write indices and clear.
- Handshakes with the ALU and memory for multi-cycle transfers; reports busy/done/err back to the controller.

---
 rtl/regfile_seq.sv | 81 ++++++++
 tb/tb_regfile_seq.sv | 122 ++++++++++++
 2 files changed

// File: rtl/regfile_seq.sv
// regfile_seq: one-command-at-a-time sequencer for the 8-entry register file,
// handshaking with the ALU and memory and reporting busy/done/err.
module regfile_seq #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [2:0] rd,
    input  logic [2:0] rs,
    input  logic       alu_done,
    input  logic       mem_ack,
    output logic       rf_clr,
    output logic       rf_we,
    output logic [2:0] rf_mux_sel,
    output logic [2:0] rf_read_seg,
    output logic [2:0] rf_write_seg,
    output logic       alu_go,
    output logic       mem_req,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [2:0] {INIT, IDLE, RD, ALU_WAIT, MEM_WAIT, WB, FIN} state_t;

    state_t           state, next;
    logic [2:0]       op_q, rd_q;
    logic [CNT_W-1:0] cnt;
    logic             err_q, waiting, acked, expired;

    always_comb begin
        next    = state;
        waiting = state == ALU_WAIT || state == MEM_WAIT;
        acked   = (state == ALU_WAIT && alu_done) || (state == MEM_WAIT && mem_ack);
        expired = cnt == CNT_W'(TIMEOUT - 1);
        case (state)
            INIT:     next = rf_clr ? IDLE : INIT;
            IDLE:     if (start) next = op == 3'd3 ? RD : op == 3'd6 ? MEM_WAIT : op == 3'd7 ? FIN : WB;
            RD:       next = ALU_WAIT;
            ALU_WAIT,
            MEM_WAIT: next = acked ? WB : expired ? FIN : state;
            WB:       next = FIN;
            FIN:      next = IDLE;
            default:  next = INIT;
        endcase
    end

    // rf_clr is registered so it stays low while reset is held and pulses once after release
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state       <= INIT;
            cnt         <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            err_q       <= 1'b0;
            rf_clr      <= 1'b0;
            rf_read_seg <= '0;
        end else begin
            state  <= next;
            rf_clr <= state == INIT && !rf_clr;
            cnt    <= waiting ? cnt + 1'b1 : '0;
            err_q  <= next == FIN && state != WB;
            if (state == IDLE && start) begin
                op_q <= op;
                rd_q <= rd;
            end
            if (next == RD && state == IDLE) rf_read_seg <= rs;
        end
    end

    assign rf_we        = state == WB;
    assign rf_mux_sel   = state == WB ? op_q : 3'b111;
    assign rf_write_seg = state == WB && op_q != 3'd4 && op_q != 3'd5 ? rd_q : 3'd0;
    assign alu_go       = state == RD;
    assign mem_req      = state == MEM_WAIT;
    assign busy         = state != IDLE;
    assign done         = state == FIN;
    assign err          = err_q;
endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq: randomized bench; each command's cycle-by-cycle output trace is
// derived from the command's latency rules and compared at the falling edge.
module tb_regfile_seq;
    localparam int TO = 15;

    logic       clk = 1'b0, clr_n = 1'b1, start = 1'b0, alu_done = 1'b0, mem_ack = 1'b0;
    logic [2:0] op = '0, rd = '0, rs = '0;
    logic       rf_clr, rf_we, alu_go, mem_req, busy, done, err;
    logic [2:0] rf_mux_sel, rf_read_seg, rf_write_seg;

    int         n_tests = 0, n_fail = 0;
    logic [2:0] last_read = '0;

    typedef struct {
        logic [15:0] v;
        bit          ack;
    } cyc_t;
    cyc_t q[$];

    always #5 clk = ~clk;

    regfile_seq #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .op(op), .rd(rd), .rs(rs),
        .alu_done(alu_done), .mem_ack(mem_ack), .rf_clr(rf_clr), .rf_we(rf_we),
        .rf_mux_sel(rf_mux_sel), .rf_read_seg(rf_read_seg), .rf_write_seg(rf_write_seg),
        .alu_go(alu_go), .mem_req(mem_req), .busy(busy), .done(done), .err(err)
    );

    function automatic logic [15:0] obs();
        return {rf_clr, rf_we, rf_mux_sel, rf_read_seg, rf_write_seg, alu_go, mem_req, busy, done, err};
    endfunction

    function automatic logic [15:0] vec(input int clr, we, mux, rseg, wseg, go, req, bsy, dn, er);
        return {1'(clr), 1'(we), 3'(mux), 3'(rseg), 3'(wseg), 1'(go), 1'(req), 1'(bsy), 1'(dn), 1'(er)};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input int we, mux, ws, go, req, dn, er, input bit ack);
        cyc_t c;
        c.v   = vec(0, we, mux, last_read, ws, go, req, 1, dn, er);
        c.ack = ack;
        q.push_back(c);
    endtask

    task automatic do_reset();
        clr_n = 1'b0; start = 1'b0; alu_done = 1'b0; mem_ack = 1'b0;
        last_read = '0;
        #1 check("rst_async", obs(), vec(0, 0, 7, 0, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        check("rst_hold", obs(), vec(0, 0, 7, 0, 0, 0, 0, 1, 0, 0));
        clr_n = 1'b1;
        #1 check("init", obs(), vec(0, 0, 7, 0, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        check("rf_clr", obs(), vec(1, 0, 7, 0, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
    endtask

    // dly: wait cycle (1..TO) in which the ack arrives, 0 = never; abort: stop after that trace index
    task automatic do_cmd(input logic [2:0] o, d, s, input int dly, input bit hold, input int abort);
        int n;
        check("idle", obs(), vec(0, 0, 7, last_read, 0, 0, 0, 0, 0, 0));
        q.delete();
        if (o == 3'd3) last_read = s;
        if (o == 3'd7) push(0, 7, 0, 0, 0, 1, 1, 0);
        else if (o == 3'd3 || o == 3'd6) begin
            if (o == 3'd3) push(0, 7, 0, 1, 0, 0, 0, 0);
            n = (dly >= 1 && dly <= TO) ? dly : TO;
            for (int i = 1; i <= n; i++) push(0, 7, 0, 0, int'(o == 3'd6), 0, 0, i == dly);
            if (dly >= 1 && dly <= TO) begin
                push(1, o, d, 0, 0, 0, 0, 0);
                push(0, 7, 0, 0, 0, 1, 0, 0);
            end else push(0, 7, 0, 0, 0, 1, 1, 0);
        end else begin
            push(1, o, (o == 3'd4 || o == 3'd5) ? 0 : d, 0, 0, 0, 0, 0);
            push(0, 7, 0, 0, 0, 1, 0, 0);
        end
        start = 1'b1; op = o; rd = d; rs = s;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            start = hold ? 1'b1 : 1'($urandom);
            op = 3'($urandom); rd = 3'($urandom); rs = 3'($urandom);
            check($sformatf("op%0d_c%0d", o, i), obs(), q[i].v);
            if (i == abort) return;
            alu_done = o == 3'd3 ? q[i].ack : 1'($urandom);
            mem_ack  = o == 3'd6 ? q[i].ack : 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0; alu_done = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        #2 do_reset();
        do_cmd(3'd1, 3'd5, 3'd0, 0, 0, -1);
        do_cmd(3'd4, 3'd6, 3'd0, 0, 0, -1);
        do_cmd(3'd5, 3'd6, 3'd0, 0, 0, -1);
        do_cmd(3'd0, 3'd2, 3'd0, 0, 0, -1);
        do_cmd(3'd2, 3'd1, 3'd0, 0, 0, -1);
        do_cmd(3'd3, 3'd7, 3'd2, 3, 0, -1);
        do_cmd(3'd6, 3'd3, 3'd0, 4, 0, -1);
        do_cmd(3'd6, 3'd4, 3'd0, 0, 0, -1);
        do_cmd(3'd6, 3'd2, 3'd0, TO, 0, -1);
        do_cmd(3'd3, 3'd1, 3'd4, 0, 0, -1);
        do_cmd(3'd3, 3'd6, 3'd5, TO, 0, -1);
        do_cmd(3'd3, 3'd7, 3'd3, 0, 0, 3);
        do_reset();
        do_cmd(3'd7, 3'd0, 3'd0, 0, 0, -1);
        do_cmd(3'd2, 3'd4, 3'd0, 0, 1, -1);
        do_cmd(3'd6, 3'd5, 3'd0, 1, 1, -1);
        for (int k = 0; k < 40; k++)
            do_cmd(3'($urandom), 3'($urandom), 3'($urandom), int'($urandom_range(0, TO)),
                   $urandom_range(0, 3) == 0, -1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
